// File: rtl/axi4_slave_read_data_channel_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared definitions for the AXI4 slave read-data path:
//   burst_e     - AXI burst encodings (FIXED / INCR / WRAP)
//   RESP_*      - read response codes (OKAY, SLVERR)
//   rd_state_e  - read-data FSM states (R_IDLE, R_FETCH, R_SEND)
// Optional feature macro used by the design: RD_ERR_RESP_EN (see top module).
// -----------------------------------------------------------------------------
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_FETCH = 2'b01,
    R_SEND  = 2'b10
  } rd_state_e;

endpackage

// File: rtl/axi4_slave_read_data_channel_if.sv
// -----------------------------------------------------------------------------
// axi4_slave_read_data_channel_if
// Bundles the read-address inputs, the R channel and the backing-memory port.
//   AR : arvalid, arready, araddr, arlen, arburst, arid
//   R  : rvalid, rready, rdata, rresp, rlast, rid, rd_busy
//   MEM: mem_rd_en, mem_raddr (byte address), mem_rdata (valid cycle after rd_en)
// Modports: slave (the read-data channel), master (address side / sink / memory).
// -----------------------------------------------------------------------------
interface axi4_slave_read_data_channel_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LENGTH = 8
) ();

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [BURST_LENGTH-1:0] arlen;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;
  logic                    rd_busy;

  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  arvalid, arready, araddr, arlen, arburst, arid,
    input  rready, mem_rdata,
    output rvalid, rdata, rresp, rlast, rid, rd_busy,
    output mem_rd_en, mem_raddr
  );

  modport master (
    output arvalid, arready, araddr, arlen, arburst, arid,
    output rready, mem_rdata,
    input  rvalid, rdata, rresp, rlast, rid, rd_busy,
    input  mem_rd_en, mem_raddr
  );

endinterface

// File: rtl/axi4_slave_read_data_channel_addr_gen.sv
// -----------------------------------------------------------------------------
// axi4_rd_addr_gen
// Next-beat address for a read burst.
//   i_addr      : current beat byte address
//   i_burst     : burst type (FIXED holds, INCR/WRAP/reserved advance)
//   o_next_addr : address of the following beat
// INCR adds one data word in bytes and wraps naturally modulo 2^ADDR_WIDTH.
// WRAP bursts are handled as INCR by this slave.
// -----------------------------------------------------------------------------
module axi4_rd_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  always_comb begin
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else begin
      o_next_addr = i_addr + STEP;
    end
  end

endmodule

// File: rtl/axi4_slave_read_data_channel.sv
// -----------------------------------------------------------------------------
// axi4_slave_read_data_channel
// AXI4 slave read-data channel: accepts a read burst from the address channel,
// fetches each beat from a word memory and returns it on the R channel.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : axi4_slave_read_data_channel_if.slave (AR inputs, R channel, memory port)
// Optional macro RD_ERR_RESP_EN: beats addressed at or beyond
// MEM_DEPTH*(DATA_WIDTH/8) skip the memory read and return rdata 0 / SLVERR.
// Without the macro every beat reads memory and responds OKAY.
//
// Beat timing: mem_rd_en is a registered pulse during the first R_FETCH cycle,
// the second R_FETCH cycle waits for mem_rdata, and the data is registered on
// the transition into R_SEND. The first rvalid therefore appears two clocks
// after the AR handshake.
// -----------------------------------------------------------------------------
module axi4_slave_read_data_channel
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LENGTH = 8,
  parameter int MEM_DEPTH    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  axi4_slave_read_data_channel_if.slave bus
);

  rd_state_e               r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [BURST_LENGTH-1:0] r_beat_cnt, w_beat_next;
  logic [1:0]              r_burst, w_burst_next;
  logic [ID_WIDTH-1:0]     r_id, w_id_next;
  logic                    r_rd_busy, w_busy_next;
  logic                    r_rvalid, w_rvalid_next;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_next;
  logic [1:0]              r_rresp, w_rresp_next;
  logic                    r_rlast, w_rlast_next;
  logic [ID_WIDTH-1:0]     r_rid, w_rid_next;
  logic                    r_mem_rd_en, w_mem_rd_en_next;
  logic [ADDR_WIDTH-1:0]   r_mem_raddr, w_mem_raddr_next;
  logic                    r_err, w_err_next;     // current beat is out of range
  logic                    r_wait, w_wait_next;   // second R_FETCH cycle

  logic [ADDR_WIDTH-1:0]   w_adv_addr;
  logic [ADDR_WIDTH-1:0]   w_fetch_addr;
  logic                    w_fetch_err;
  logic                    w_issue;

  axi4_rd_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_burst     (r_burst),
    .o_next_addr (w_adv_addr)
  );

  // A fetch is launched either from the AR handshake (new burst address) or
  // from an R handshake (advanced address of the next beat).
  assign w_fetch_addr = (r_state == R_IDLE) ? bus.araddr : w_adv_addr;

`ifdef RD_ERR_RESP_EN
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * (DATA_WIDTH / 8));
  assign w_fetch_err = ({1'b0, w_fetch_addr} >= MEM_LIMIT);
`else
  assign w_fetch_err = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_beat_next      = r_beat_cnt;
    w_burst_next     = r_burst;
    w_id_next        = r_id;
    w_busy_next      = r_rd_busy;
    w_rvalid_next    = r_rvalid;
    w_rdata_next     = r_rdata;
    w_rresp_next     = r_rresp;
    w_rlast_next     = r_rlast;
    w_rid_next       = r_rid;
    w_mem_rd_en_next = 1'b0;
    w_mem_raddr_next = r_mem_raddr;
    w_err_next       = r_err;
    w_wait_next      = r_wait;
    w_issue          = 1'b0;

    case (r_state)
      R_IDLE: begin
        if (bus.arvalid && bus.arready) begin
          w_addr_next  = bus.araddr;
          w_beat_next  = bus.arlen;
          w_burst_next = bus.arburst;
          w_id_next    = bus.arid;
          w_busy_next  = 1'b1;
          w_issue      = 1'b1;
          w_state_next = R_FETCH;
        end
      end

      R_FETCH: begin
        if (!r_wait) begin
          w_wait_next = 1'b1;
        end else begin
          w_wait_next   = 1'b0;
          w_rvalid_next = 1'b1;
          w_rdata_next  = r_err ? '0 : bus.mem_rdata;
          w_rresp_next  = r_err ? RESP_SLVERR : RESP_OKAY;
          w_rlast_next  = (r_beat_cnt == '0);
          w_rid_next    = r_id;
          w_state_next  = R_SEND;
        end
      end

      R_SEND: begin
        if (r_rvalid && bus.rready) begin
          w_rvalid_next = 1'b0;
          if (r_rlast) begin
            w_rlast_next = 1'b0;
            w_busy_next  = 1'b0;
            w_state_next = R_IDLE;
          end else begin
            w_beat_next  = r_beat_cnt - 1'b1;
            w_addr_next  = w_adv_addr;
            w_issue      = 1'b1;
            w_state_next = R_FETCH;
          end
        end
      end

      default: begin
        w_state_next = R_IDLE;
      end
    endcase

    // Registered memory request: high during the first R_FETCH cycle.
    if (w_issue) begin
      w_mem_rd_en_next = !w_fetch_err;
      w_mem_raddr_next = w_fetch_addr;
      w_err_next       = w_fetch_err;
      w_wait_next      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_beat_cnt  <= '0;
      r_burst     <= '0;
      r_id        <= '0;
      r_rd_busy   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_rlast     <= 1'b0;
      r_rid       <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_raddr <= '0;
      r_err       <= 1'b0;
      r_wait      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_beat_cnt  <= w_beat_next;
      r_burst     <= w_burst_next;
      r_id        <= w_id_next;
      r_rd_busy   <= w_busy_next;
      r_rvalid    <= w_rvalid_next;
      r_rdata     <= w_rdata_next;
      r_rresp     <= w_rresp_next;
      r_rlast     <= w_rlast_next;
      r_rid       <= w_rid_next;
      r_mem_rd_en <= w_mem_rd_en_next;
      r_mem_raddr <= w_mem_raddr_next;
      r_err       <= w_err_next;
      r_wait      <= w_wait_next;
    end
  end

  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.rresp     = r_rresp;
  assign bus.rlast     = r_rlast;
  assign bus.rid       = r_rid;
  assign bus.rd_busy   = r_rd_busy;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_raddr = r_mem_raddr;

endmodule
